// File: rtl/fp_mul_arbiter_pkg.sv
// Shared types for the FP multiplier arbiter: opcodes, operand width and the in-flight tag record.
package fp_mul_arbiter_pkg;

  localparam int FP_WIDTH      = 32;
  localparam int OP_WIDTH      = 6;
  localparam int MAX_TAG_WIDTH = 3;

  localparam logic [OP_WIDTH-1:0] OP_FMUL = 6'h22;
  localparam logic [OP_WIDTH-1:0] OP_ITOF = 6'h2a;

  typedef struct packed {
    logic                     valid;
    logic [MAX_TAG_WIDTH-1:0] tag;
  } arb_tag_t;

endpackage

// File: rtl/fp_mul_arbiter_if.sv
// Requester and multiplier bus of the FP multiplier arbiter; slave is the arbiter side.
interface fp_mul_arbiter_if
  import fp_mul_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4
);

  logic [NUM_REQUESTERS-1:0]          req_valid;
  logic [OP_WIDTH*NUM_REQUESTERS-1:0] req_operation;
  logic [FP_WIDTH*NUM_REQUESTERS-1:0] req_operand1;
  logic [FP_WIDTH*NUM_REQUESTERS-1:0] req_operand2;
  logic [NUM_REQUESTERS-1:0]          req_ready;
  logic                               mul_valid_o;
  logic [OP_WIDTH-1:0]                mul_operation_o;
  logic [FP_WIDTH-1:0]                mul_operand1_o;
  logic [FP_WIDTH-1:0]                mul_operand2_o;
  logic [FP_WIDTH-1:0]                mul_result_i;
  logic [NUM_REQUESTERS-1:0]          resp_valid;
  logic [FP_WIDTH-1:0]                resp_result;

  modport slave (
    input  req_valid, req_operation, req_operand1, req_operand2, mul_result_i,
    output req_ready, mul_valid_o, mul_operation_o, mul_operand1_o, mul_operand2_o,
    output resp_valid, resp_result
  );

  modport master (
    output req_valid, req_operation, req_operand1, req_operand2, mul_result_i,
    input  req_ready, mul_valid_o, mul_operation_o, mul_operand1_o, mul_operand2_o,
    input  resp_valid, resp_result
  );

endinterface

// File: rtl/fp_mul_arbiter_rr_arbiter.sv
// Round-robin arbiter: first set request at or above rr_ptr (wrapping), pointer moves past the winner.
module fp_mul_arbiter_rr_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int TAG_WIDTH      = $clog2(NUM_REQUESTERS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] req_i,
  input  logic                      update_en_i,
  output logic [NUM_REQUESTERS-1:0] grant_o,
  output logic [TAG_WIDTH-1:0]      grant_idx_o,
  output logic                      grant_vld_o
);

  logic [TAG_WIDTH-1:0]        rr_ptr_q, rr_ptr_d;
  logic [2*NUM_REQUESTERS-1:0] req_rot;
  int                          off;
  int                          sum;
  int                          nxt;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    rr_ptr_d    = rr_ptr_q;
    off         = 0;
    sum         = 0;
    nxt         = 0;
    // Doubling the vector turns the wrap-around search into a plain lowest-bit search.
    req_rot = {req_i, req_i} >> rr_ptr_q;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (!grant_vld_o && req_rot[i]) begin
        grant_vld_o = 1'b1;
        off         = i;
      end
    end
    sum = int'(rr_ptr_q) + off;
    if (sum >= NUM_REQUESTERS) sum = sum - NUM_REQUESTERS;
    nxt = sum + 1;
    if (nxt == NUM_REQUESTERS) nxt = 0;
    if (grant_vld_o) begin
      grant_idx_o = TAG_WIDTH'(sum);
      rr_ptr_d    = TAG_WIDTH'(nxt);
    end
    for (int j = 0; j < NUM_REQUESTERS; j++) begin
      grant_o[j] = grant_vld_o && (grant_idx_o == TAG_WIDTH'(j));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else if (update_en_i) begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one fixed-latency FP multiplier among NUM_REQUESTERS ports and routes results back by tag.
// Optional FP_MUL_ARB_PERF_EN adds issue and conflict performance counters.
module fp_mul_arbiter
  import fp_mul_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int MUL_LATENCY    = 4,
  parameter int TAG_WIDTH      = $clog2(NUM_REQUESTERS)
) (
  input  logic                  clk,
  input  logic                  reset,
  fp_mul_arbiter_if.slave       bus
`ifdef FP_MUL_ARB_PERF_EN
  ,
  output logic [31:0]           perf_issue_count,
  output logic [31:0]           perf_conflict_count
`endif
);

  logic [NUM_REQUESTERS-1:0] busy_q, busy_d;
  logic [NUM_REQUESTERS-1:0] eligible;
  logic [NUM_REQUESTERS-1:0] grant;
  logic [NUM_REQUESTERS-1:0] resp_valid;
  logic [TAG_WIDTH-1:0]      grant_idx;
  logic                      grant_vld;
  arb_tag_t                  issue_q;
  arb_tag_t                  tag_pipe_q [MUL_LATENCY];
  logic [OP_WIDTH-1:0]       mul_op_q, mul_op_d;
  logic [FP_WIDTH-1:0]       mul_a_q, mul_a_d;
  logic [FP_WIDTH-1:0]       mul_b_q, mul_b_d;

  // A response frees its requester in the same cycle, allowing reissue right away.
  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      resp_valid[i] = !reset && tag_pipe_q[MUL_LATENCY-1].valid &&
                      (tag_pipe_q[MUL_LATENCY-1].tag == MAX_TAG_WIDTH'(i));
    end
  end

  assign eligible = bus.req_valid & ~(busy_q & ~resp_valid) & {NUM_REQUESTERS{~reset}};
  assign busy_d   = (busy_q & ~resp_valid) | grant;

  fp_mul_arbiter_rr_arbiter #(
    .NUM_REQUESTERS (NUM_REQUESTERS),
    .TAG_WIDTH      (TAG_WIDTH)
  ) u_rr_arbiter (
    .clk         (clk),
    .reset       (reset),
    .req_i       (eligible),
    .update_en_i (grant_vld),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_vld_o (grant_vld)
  );

  always_comb begin
    mul_op_d = mul_op_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (grant[i]) begin
        mul_op_d = bus.req_operation[i*OP_WIDTH +: OP_WIDTH];
        mul_a_d  = bus.req_operand1[i*FP_WIDTH +: FP_WIDTH];
        mul_b_d  = bus.req_operand2[i*FP_WIDTH +: FP_WIDTH];
      end
    end
  end

  // issue_q is the multiplier input stage; the tag pipe then covers MUL_LATENCY cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_q  <= '0;
      mul_op_q <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      busy_q   <= '0;
      for (int s = 0; s < MUL_LATENCY; s++) tag_pipe_q[s] <= '0;
    end else begin
      issue_q       <= '{valid: grant_vld, tag: MAX_TAG_WIDTH'(grant_idx)};
      mul_op_q      <= mul_op_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      busy_q        <= busy_d;
      tag_pipe_q[0] <= issue_q;
      for (int s = 1; s < MUL_LATENCY; s++) tag_pipe_q[s] <= tag_pipe_q[s-1];
    end
  end

  assign bus.req_ready       = grant;
  assign bus.mul_valid_o     = issue_q.valid;
  assign bus.mul_operation_o = mul_op_q;
  assign bus.mul_operand1_o  = mul_a_q;
  assign bus.mul_operand2_o  = mul_b_q;
  assign bus.resp_valid      = resp_valid;
  assign bus.resp_result     = bus.mul_result_i;

`ifdef FP_MUL_ARB_PERF_EN
  logic [31:0] perf_issue_q;
  logic [31:0] perf_conflict_q;
  logic        conflict;

  assign conflict = $countones(eligible) > 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issue_q    <= '0;
      perf_conflict_q <= '0;
    end else begin
      perf_issue_q    <= perf_issue_q + 32'(grant_vld);
      perf_conflict_q <= perf_conflict_q + 32'(conflict);
    end
  end

  assign perf_issue_count    = perf_issue_q;
  assign perf_conflict_count = perf_conflict_q;
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Self-checking bench for fp_mul_arbiter: reference arbiter model, multiplier model and per-requester scoreboard.
module tb_fp_mul_arbiter;
  import fp_mul_arbiter_pkg::*;

  localparam int N = 4;
  localparam int L = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp_mul_arbiter_if #(.NUM_REQUESTERS(N)) bus ();

`ifdef FP_MUL_ARB_PERF_EN
  logic [31:0] perf_issue_count;
  logic [31:0] perf_conflict_count;
`endif

  fp_mul_arbiter #(.NUM_REQUESTERS(N), .MUL_LATENCY(L)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FP_MUL_ARB_PERF_EN
    ,
    .perf_issue_count    (perf_issue_count),
    .perf_conflict_count (perf_conflict_count)
`endif
  );

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail_to(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference multiplier (normal numbers, truncating) ----------------
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {a[31] ^ b[31], 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 10'd1;
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  function automatic logic [31:0] itof(input logic [31:0] a);
    logic [31:0] mag;
    logic [31:0] mant;
    int          msb;
    if (a == 32'd0) return 32'd0;
    mag = a[31] ? (~a + 32'd1) : a;
    msb = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) msb = i;
    mant = (msb <= 23) ? (mag << (23 - msb)) : (mag >> (msb - 23));
    return {a[31], 8'(127 + msb), mant[22:0]};
  endfunction

  function automatic logic [31:0] ref_mul(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    return (op == OP_ITOF) ? itof(a) : fmul(a, b);
  endfunction

  logic [31:0] mpipe [L];
  always @(posedge clk) begin
    mpipe[0] <= bus.mul_valid_o ? ref_mul(bus.mul_operation_o, bus.mul_operand1_o, bus.mul_operand2_o)
                                : 32'hDEAD_BEEF;
    for (int k = 1; k < L; k++) mpipe[k] <= mpipe[k-1];
  end
  assign bus.mul_result_i = mpipe[L-1];

  // ---------------- reference arbiter + scoreboard ----------------
  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t        sbq [N][$];
  logic [N-1:0] m_inflight;
  int           m_ptr;
  logic         m_prev_vld;
  logic [5:0]   m_prev_op;
  logic [31:0]  m_prev_a, m_prev_b;
  int           m_issues, m_conflicts;
  int           g2_q[$];
  logic [N-1:0] exp_resp, elig, exp_grant;
  int           g, idx;

  always @(negedge clk) begin
    if (reset) begin
      chk("ready_in_reset", 32'(bus.req_ready), 32'd0);
      chk("resp_in_reset", 32'(bus.resp_valid), 32'd0);
      for (int i = 0; i < N; i++) sbq[i].delete();
      m_inflight  = '0;
      m_ptr       = 0;
      m_prev_vld  = 1'b0;
      m_issues    = 0;
      m_conflicts = 0;
    end else begin
      chk("mul_valid", 32'(bus.mul_valid_o), 32'(m_prev_vld));
      if (m_prev_vld) begin
        chk("mul_operation", 32'(bus.mul_operation_o), 32'(m_prev_op));
        chk("mul_operand1", bus.mul_operand1_o, m_prev_a);
        chk("mul_operand2", bus.mul_operand2_o, m_prev_b);
      end
`ifdef FP_MUL_ARB_PERF_EN
      chk("perf_issue_track", perf_issue_count, 32'(m_issues));
      chk("perf_conflict_track", perf_conflict_count, 32'(m_conflicts));
`endif
      exp_resp = '0;
      for (int i = 0; i < N; i++)
        if (sbq[i].size() > 0 && sbq[i][0].due == cyc) exp_resp[i] = 1'b1;
      chk("resp_valid", 32'(bus.resp_valid), 32'(exp_resp));
      for (int i = 0; i < N; i++) begin
        if (exp_resp[i]) begin
          chk("resp_result", bus.resp_result, sbq[i][0].res);
          void'(sbq[i].pop_front());
        end
      end
      elig      = bus.req_valid & ~(m_inflight & ~exp_resp);
      exp_grant = '0;
      g         = -1;
      for (int off = 0; off < N; off++) begin
        idx = (m_ptr + off) % N;
        if (g < 0 && elig[idx]) g = idx;
      end
      if (g >= 0) exp_grant[g] = 1'b1;
      chk("req_ready", 32'(bus.req_ready), 32'(exp_grant));
      if ($countones(elig) > 1) m_conflicts++;
      m_inflight = m_inflight & ~exp_resp;
      m_prev_vld = (g >= 0);
      if (g >= 0) begin
        m_prev_op = bus.req_operation[g*6 +: 6];
        m_prev_a  = bus.req_operand1[g*32 +: 32];
        m_prev_b  = bus.req_operand2[g*32 +: 32];
        sbq[g].push_back('{res: ref_mul(m_prev_op, m_prev_a, m_prev_b), due: cyc + 1 + L});
        m_inflight[g] = 1'b1;
        m_ptr         = (g + 1) % N;
        m_issues++;
        if (g == 2) g2_q.push_back(cyc);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req_operation[r*6 +: 6]  = op;
    bus.req_operand1[r*32 +: 32] = a;
    bus.req_operand2[r*32 +: 32] = b;
  endtask

  task automatic issue_one(input int r, input logic [5:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] expv, input string name);
    bit got;
    int hs_cyc;
    step();
    set_req(r, op, a, b);
    bus.req_valid[r] = 1'b1;
    got = 1'b0;
    hs_cyc = 0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (bus.req_ready[r]) begin
        got = 1'b1;
        hs_cyc = cyc;
      end
    end
    if (!got) fail_to({name, "_grant"});
    step();
    bus.req_valid[r] = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (bus.resp_valid[r]) begin
        got = 1'b1;
        chk(name, bus.resp_result, expv);
        chk({name, "_latency"}, 32'(cyc - hs_cyc), 32'(1 + L));
      end
    end
    if (!got) fail_to({name, "_resp"});
  endtask

  typedef struct {
    int          rq;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expv;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    bit got;
    int hs;
    tbl[0] = '{1, OP_FMUL, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000};
    tbl[1] = '{0, OP_FMUL, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000};
    tbl[2] = '{2, OP_FMUL, 32'hBF80_0000, 32'h4080_0000, 32'hC080_0000};
    tbl[3] = '{3, OP_FMUL, 32'h3F00_0000, 32'h3F00_0000, 32'h3E80_0000};
    tbl[4] = '{1, OP_ITOF, 32'd5,         32'd0,         32'h40A0_0000};
    tbl[5] = '{2, OP_ITOF, 32'd1,         32'd0,         32'h3F80_0000};
    tbl[6] = '{3, OP_ITOF, 32'hFFFF_FFFE, 32'd0,         32'hC000_0000};
    tbl[7] = '{0, OP_ITOF, 32'd0,         32'd0,         32'h0000_0000};

    reset             = 1'b1;
    bus.req_valid     = '0;
    bus.req_operation = '0;
    bus.req_operand1  = '0;
    bus.req_operand2  = '0;
    repeat (3) step();
    reset = 1'b0;

    // idle: the monitor expects ready/valid/resp all low
    repeat (10) step();

    for (int v = 0; v < 8; v++)
      issue_one(tbl[v].rq, tbl[v].op, tbl[v].a, tbl[v].b, tbl[v].expv, $sformatf("vec%0d", v));

    // all four requesters continuously with fresh operands every cycle
    for (int c = 0; c < 40; c++) begin
      step();
      bus.req_valid = '1;
      for (int r = 0; r < N; r++)
        set_req(r, ($urandom_range(0, 1) == 0) ? OP_FMUL : OP_ITOF, $urandom, $urandom);
    end
    step();
    bus.req_valid = '0;
    repeat (10) step();

    // single requester re-requesting immediately
    g2_q.delete();
    set_req(2, OP_FMUL, 32'h4040_0000, 32'h4040_0000);
    bus.req_valid = 4'b0100;
    repeat (25) step();
    bus.req_valid = '0;
    repeat (10) step();
    chk("reissue_count", 32'(g2_q.size()), 32'd5);
    for (int i = 1; i < g2_q.size(); i++)
      chk("reissue_spacing", 32'(g2_q[i] - g2_q[i-1]), 32'(L + 1));

    // reset one cycle after a grant to requester 3
    step();
    set_req(3, OP_FMUL, 32'h4000_0000, 32'h4000_0000);
    bus.req_valid[3] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = bus.req_ready[3];
    end
    if (!got) fail_to("pre_reset_grant");
    step();
    bus.req_valid = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.req_valid[3] = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(bus.req_ready), 32'h8);
    step();
    bus.req_valid = '0;
    repeat (12) step();

`ifdef FP_MUL_ARB_PERF_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (2) step();
    bus.req_valid = 4'b0111;
    hs = 0;
    for (int k = 0; k < 60 && hs < 6; k++) begin
      @(negedge clk);
      hs += $countones(bus.req_valid & bus.req_ready);
    end
    if (hs < 6) fail_to("perf_grants");
    step();
    bus.req_valid = '0;
    repeat (10) step();
    chk("perf_issue_count", perf_issue_count, 32'd6);
    // cycle 0 sees three eligible, cycle 1 sees two; every later grant is alone
    chk("perf_conflict_count", perf_conflict_count, 32'd2);
`else
    hs = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
